// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple chain with a registered carry.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d, sum_q, sum_d;
  logic             c_q, c_d, co_q, co_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIGIT-1:0] dsum;
  logic             cout;
  logic [WIDTH-1:0] shifted;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
  logic             cmsb;
`endif

  // DIGIT-cell ripple chain on the low digit of the operand shift registers
  assign {cout, dsum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  // New digit enters at the MSB end; after STEPS shifts the register holds the full result
  assign shifted = (psum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
`ifdef SERIAL_ADDER_OVF_EN
  assign cmsb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = ci ^ sub;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        c_d    = cout;
        psum_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = shifted;
          co_d    = cout;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = cmsb ^ cout;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 16-bit/4-digit instance plus an 8-bit/1-digit instance.
module tb_serial_adder;

`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, sub, ci;
  logic [15:0] a, b, sum;
  logic        busy, done, co, ovf;
  logic        start8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, co8, ovf8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a8), .b(b8), .ci(ci),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8), .ovf(ovf8)
  );

  typedef struct {
    logic        s;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vc;
    logic [15:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op on the 16-bit instance; lat counts cycles from the start cycle to done
  task automatic run16(input logic s, input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, output int lat, output int bcnt);
    @(negedge clk);
    sub = s; a = va; b = vb; ci = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt;
    vecs[0] = '{1'b0, 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; sub = 1'b0; ci = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset co", co, 0);
    check("reset ovf", ovf, 0);
    check("reset8 sum/done", {sum8, done8, busy8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run16(vecs[i].s, vecs[i].va, vecs[i].vb, vecs[i].vc, lat, bcnt);
      check($sformatf("v%0d latency", i), lat, 5);
      check($sformatf("v%0d busy cycles", i), bcnt, 4);
      check($sformatf("v%0d sum", i), sum, vecs[i].es);
      check($sformatf("v%0d co", i), co, vecs[i].eco);
      check($sformatf("v%0d ovf", i), ovf, vecs[i].eov & OVF_ON);
      @(negedge clk);
      check($sformatf("v%0d done pulse", i), done, 0);
      check($sformatf("v%0d sum held", i), sum, vecs[i].es);
    end

    // start pulsed mid-RUN with different operands must be ignored
    @(negedge clk);
    sub = 1'b0; a = 16'h1234; b = 16'h0FF0; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sub = 1'b1; a = 16'hFFFF; b = 16'hAAAA; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("midrun latency", lat, 5);
    check("midrun sum", sum, 16'h2224);
    check("midrun co", co, 0);

    // start held in the DONE cycle: second op follows with no idle gap
    @(negedge clk);
    sub = 1'b0; a = 16'h0001; b = 16'h0002; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b first sum", sum, 16'h0003);
    a = 16'h0010; b = 16'h0020; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b no double done", done, 0);
    check("b2b busy", busy, 1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b second latency", lat, 5);
    check("b2b second sum", sum, 16'h0030);

    // asynchronous reset during step 2 clears everything
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst sum", sum, 0);
    check("midrst co/ovf", {co, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post-rst idle", {busy, done}, 0);
    run16(1'b1, 16'h0007, 16'h0005, 1'b0, lat, bcnt);
    check("post-rst latency", lat, 5);
    check("post-rst sum", sum, 16'h0002);
    check("post-rst co", co, 1);

    // WIDTH=8, DIGIT=1 instance
    @(negedge clk);
    sub = 1'b0; ci = 1'b0; a8 = 8'hA5; b8 = 8'h5B; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w8 latency", lat, 9);
    check("w8 sum", sum8, 8'h00);
    check("w8 co", co8, 1);
    check("w8 ovf", ovf8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
